// File: rtl/regfile_wb_scheduler.sv
// Round-robin writeback arbiter for the single register-bank write port, plus a pending-write
// scoreboard that stalls issue on RAW/WAW hazards. Optional bypass: define REGFILE_WB_BYPASS_EN.
module regfile_wb_scheduler #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          wb0_valid,
  input  logic [AW-1:0] wb0_addr,
  input  logic [DW-1:0] wb0_data,
  output logic          wb0_ready,
  input  logic          wb1_valid,
  input  logic [AW-1:0] wb1_addr,
  input  logic [DW-1:0] wb1_data,
  output logic          wb1_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_ain,
  output logic [DW-1:0] rf_din,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rs,
  input  logic [AW-1:0] issue_ra,
  input  logic [AW-1:0] issue_rd,
  output logic          issue_stall
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic          byp_rs,
  output logic          byp_ra
`endif
);

  logic            last_grant;  // index of the port granted most recently
  logic            grant0;
  logic            grant1;
  logic            accept;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            issue_fire;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;
  logic [NREG-1:0] live;

  // Grants depend only on the valids and history, never on the requester's own state.
  assign grant0    = wb0_valid & (~wb1_valid | last_grant);
  assign grant1    = wb1_valid & (~wb0_valid | ~last_grant);
  assign wb0_ready = grant0;
  assign wb1_ready = grant1;
  assign accept    = grant0 | grant1;
  assign sel_addr  = grant1 ? wb1_addr : wb0_addr;
  assign sel_data  = grant1 ? wb1_data : wb0_data;

`ifdef REGFILE_WB_BYPASS_EN
  // A write sitting on the bank port this cycle is forwarded, so its pending bit no longer blocks.
  assign live   = pending & ~({{(NREG-1){1'b0}}, rf_we} << rf_ain);
  assign byp_rs = rf_we & (rf_ain == issue_rs) & (issue_rs != '0);
  assign byp_ra = rf_we & (rf_ain == issue_ra) & (issue_ra != '0);
`else
  assign live   = pending;
`endif

  assign issue_stall = issue_valid & (live[issue_rs] | live[issue_ra] | live[issue_rd]);
  assign issue_fire  = issue_valid & ~issue_stall & (issue_rd != '0);

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    pending_nxt = pending;
    if (rf_we) pending_nxt[rf_ain] = 1'b0;
    // Set is applied after clear: a newer producer for the same register stays outstanding.
    if (issue_fire) pending_nxt[issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // NOTE: the bank-facing datapath is reset too, so rf_ain/rf_din read as 0 rather than X after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      rf_we      <= 1'b0;
      rf_ain     <= '0;
      rf_din     <= '0;
      pending    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      pending <= pending_nxt;
      rf_we   <= accept & (sel_addr != '0);
      if (accept) begin
        last_grant <= grant1;
        rf_ain     <= sel_addr;
        rf_din     <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: table-driven arbitration vectors with a
// writeback scoreboard, plus hand-written scoreboard/stall/reset sequences.
module tb_regfile_wb_scheduler;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clock;
  logic          reset_n;
  logic          wb0_valid, wb1_valid;
  logic [AW-1:0] wb0_addr, wb1_addr;
  logic [DW-1:0] wb0_data, wb1_data;
  logic          wb0_ready, wb1_ready;
  logic          rf_we;
  logic [AW-1:0] rf_ain;
  logic [DW-1:0] rf_din;
  logic          issue_valid;
  logic [AW-1:0] issue_rs, issue_ra, issue_rd;
  logic          issue_stall;
`ifdef REGFILE_WB_BYPASS_EN
  logic          byp_rs, byp_ra;
`endif

  regfile_wb_scheduler #(.NREG(32), .AW(AW), .DW(DW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .wb0_valid   (wb0_valid),
    .wb0_addr    (wb0_addr),
    .wb0_data    (wb0_data),
    .wb0_ready   (wb0_ready),
    .wb1_valid   (wb1_valid),
    .wb1_addr    (wb1_addr),
    .wb1_data    (wb1_data),
    .wb1_ready   (wb1_ready),
    .rf_we       (rf_we),
    .rf_ain      (rf_ain),
    .rf_din      (rf_din),
    .issue_valid (issue_valid),
    .issue_rs    (issue_rs),
    .issue_ra    (issue_ra),
    .issue_rd    (issue_rd),
    .issue_stall (issue_stall)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .byp_rs      (byp_rs),
    .byp_ra      (byp_ra)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          r0;
    logic          r1;
  } wb_vec_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] ain;
    logic [DW-1:0] din;
  } wr_exp_t;

  localparam int NV = 9;
  wb_vec_t vec [NV];
  wr_exp_t exp_q[$];
  wr_exp_t e;
  logic [AW-1:0] last_ain;
  logic [DW-1:0] last_din;
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    else passes++;
  endtask

  task automatic idle_inputs();
    wb0_valid = 1'b0; wb0_addr = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_addr = '0; wb1_data = '0;
    issue_valid = 1'b0; issue_rs = '0; issue_ra = '0; issue_rd = '0;
  endtask

  task automatic issue(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] ra,
                       input logic [AW-1:0] rd);
    issue_valid = v; issue_rs = rs; issue_ra = ra; issue_rd = rd;
  endtask

  initial begin
    // Arbitration sequence starting from reset (port 0 wins first contention).
    vec[0] = '{1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0};
    vec[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
    vec[2] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd10, 32'h0000A0A0, 1'b0, 1'b1};
    vec[3] = '{1'b1, 5'd4, 32'h44440001, 1'b1, 5'd8, 32'h88880001, 1'b1, 1'b0};
    vec[4] = '{1'b1, 5'd5, 32'h55550002, 1'b1, 5'd8, 32'h88880001, 1'b0, 1'b1};
    vec[5] = '{1'b1, 5'd5, 32'h55550002, 1'b1, 5'd9, 32'h99990003, 1'b1, 1'b0};
    vec[6] = '{1'b1, 5'd6, 32'h66660004, 1'b1, 5'd9, 32'h99990003, 1'b0, 1'b1};
    vec[7] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h00001234, 1'b0, 1'b1};
    vec[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0};

    idle_inputs();
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("reset_rf_we", rf_we, 1'b0);
    check("reset_rf_ain", rf_ain, 0);
    check("reset_rf_din", rf_din, 0);
    issue(1'b1, 5'd1, 5'd2, 5'd0);
    #1;
    check("reset_no_stall", issue_stall, 1'b0);
    issue(1'b0, 5'd0, 5'd0, 5'd0);
    last_ain = '0;
    last_din = '0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      wb0_valid = vec[i].v0; wb0_addr = vec[i].a0; wb0_data = vec[i].d0;
      wb1_valid = vec[i].v1; wb1_addr = vec[i].a1; wb1_data = vec[i].d1;
      #1;
      check($sformatf("vec%0d_wb0_ready", i), wb0_ready, vec[i].r0);
      check($sformatf("vec%0d_wb1_ready", i), wb1_ready, vec[i].r1);
      if (vec[i].r0)      exp_q.push_back('{(vec[i].a0 != 0), vec[i].a0, vec[i].d0});
      else if (vec[i].r1) exp_q.push_back('{(vec[i].a1 != 0), vec[i].a1, vec[i].d1});
      else                exp_q.push_back('{1'b0, last_ain, last_din});
      last_ain = exp_q[$].ain;
      last_din = exp_q[$].din;
      @(posedge clock);
      #1;
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("vec%0d_rf_we", i), rf_we, e.we);
        check($sformatf("vec%0d_rf_ain", i), rf_ain, e.ain);
        check($sformatf("vec%0d_rf_din", i), rf_din, e.din);
      end
    end

    // RAW hazard on r5, resolved by an LSU writeback.
    @(negedge clock);
    idle_inputs();
    issue(1'b1, 5'd0, 5'd0, 5'd5);
    #1;
    check("raw_issue_rd5_no_stall", issue_stall, 1'b0);
    @(negedge clock);
    issue(1'b1, 5'd5, 5'd0, 5'd0);
    wb1_valid = 1'b1; wb1_addr = 5'd5; wb1_data = 32'h00000055;
    #1;
    check("raw_rs5_stall", issue_stall, 1'b1);
    check("raw_wb1_ready", wb1_ready, 1'b1);
    @(negedge clock);
    wb1_valid = 1'b0;
    #1;
    check("raw_rf_we", rf_we, 1'b1);
    check("raw_rf_ain", rf_ain, 5);
`ifdef REGFILE_WB_BYPASS_EN
    check("raw_bypass_stall_drops", issue_stall, 1'b0);
    check("raw_byp_rs", byp_rs, 1'b1);
    check("raw_byp_ra", byp_ra, 1'b0);
`else
    check("raw_stall_held_during_we", issue_stall, 1'b1);
`endif
    @(negedge clock);
    #1;
    check("raw_stall_cleared", issue_stall, 1'b0);
    issue(1'b0, 5'd0, 5'd0, 5'd0);

    // Set and clear of r7 on the same edge: set wins.
    @(negedge clock);
    wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h00000077;
    #1;
    check("setclr_wb0_ready", wb0_ready, 1'b1);
    @(negedge clock);
    wb0_valid = 1'b0;
    issue(1'b1, 5'd0, 5'd0, 5'd7);
    #1;
    check("setclr_rf_we", rf_we, 1'b1);
    check("setclr_rf_ain", rf_ain, 7);
    check("setclr_issue_rd7_no_stall", issue_stall, 1'b0);
    @(negedge clock);
    issue(1'b1, 5'd0, 5'd7, 5'd0);
    #1;
    check("setclr_rf_we_low", rf_we, 1'b0);
    check("setclr_ra7_stall", issue_stall, 1'b1);
    issue(1'b1, 5'd0, 5'd0, 5'd0);
    #1;
    check("r0_sources_no_stall", issue_stall, 1'b0);
    issue(1'b0, 5'd0, 5'd0, 5'd0);

    // Asynchronous reset in the middle of a write with pending r2 and r9.
    @(negedge clock);
    issue(1'b1, 5'd0, 5'd0, 5'd2);
    @(negedge clock);
    issue(1'b1, 5'd0, 5'd0, 5'd9);
    #1;
    check("rst_set_r9_no_stall", issue_stall, 1'b0);
    @(negedge clock);
    issue(1'b0, 5'd0, 5'd0, 5'd0);
    wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h00000033;
    @(negedge clock);
    wb0_valid = 1'b0;
    issue(1'b1, 5'd2, 5'd0, 5'd0);
    #1;
    check("rst_pre_rf_we", rf_we, 1'b1);
    check("rst_pre_r2_stall", issue_stall, 1'b1);
    reset_n = 1'b0;
    #1;
    check("rst_async_rf_we", rf_we, 1'b0);
    check("rst_async_rf_ain", rf_ain, 0);
    check("rst_async_r2_clear", issue_stall, 1'b0);
    #4;
    reset_n = 1'b1;
    @(negedge clock);
    issue(1'b1, 5'd2, 5'd9, 5'd9);
    wb0_valid = 1'b1; wb0_addr = 5'd11; wb0_data = 32'h0000000B;
    wb1_valid = 1'b1; wb1_addr = 5'd12; wb1_data = 32'h0000000C;
    #1;
    check("rst_pending_cleared", issue_stall, 1'b0);
    check("rst_contention_wb0_ready", wb0_ready, 1'b1);
    check("rst_contention_wb1_ready", wb1_ready, 1'b0);
    @(negedge clock);
    idle_inputs();
    #1;
    check("rst_post_rf_ain", rf_ain, 11);
    check("rst_post_rf_din", rf_din, 32'h0000000B);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
